// File: rtl/bp_be_cache_req_arb.sv
// Round-robin arbiter that funnels several backend requesters into one LCE request port.
// Each grant is held through its metadata and completion phases before the next grant is made.
//
// state  | meaning
// e_idle | arbitrate; winner's request is presented to the LCE
// e_meta | request accepted; waiting for the granted channel's metadata
// e_busy | metadata sent; waiting for LCE completion
module bp_be_cache_req_arb #(
   parameter int num_req_p    = 2,
   parameter int req_width_p  = 64,
   parameter int meta_width_p = 8,
   localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [num_req_p*req_width_p-1:0]  req_i,
   input  logic [num_req_p-1:0]              req_v_i,
   output logic [num_req_p-1:0]              req_ready_o,
   input  logic [num_req_p*meta_width_p-1:0] meta_i,
   input  logic [num_req_p-1:0]              meta_v_i,
   output logic [num_req_p-1:0]              complete_o,
   output logic [req_width_p-1:0]            cache_req_o,
   output logic                              cache_req_v_o,
   input  logic                              cache_req_ready_i,
   output logic [meta_width_p-1:0]           cache_req_metadata_o,
   output logic                              cache_req_metadata_v_o,
   input  logic                              cache_req_complete_i,
   output logic [id_width_lp-1:0]            grant_id_o,
   output logic                              err_o
);

   typedef enum logic [1:0] {e_idle, e_meta, e_busy} state_e;

   state_e                 state_r, state_n;
   logic [id_width_lp-1:0] grant_r, grant_n;
   logic [id_width_lp-1:0] last_grant_r, last_grant_n;
   logic                   err_r, err_n;
   logic [id_width_lp-1:0] winner;
   logic                   any_v;
   logic                   found;
   int                     idx;

   logic [req_width_p-1:0]  req_arr  [num_req_p];
   logic [meta_width_p-1:0] meta_arr [num_req_p];

   for (genvar n = 0; n < num_req_p; n++) begin : g_unpack
      assign req_arr[n]  = req_i[n*req_width_p +: req_width_p];
      assign meta_arr[n] = meta_i[n*meta_width_p +: meta_width_p];
   end

   assign any_v = |req_v_i;

   // Search starts one past the last completed grant so every channel gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = last_grant_r;
      idx    = 0;
      for (int i = 0; i < num_req_p; i++) begin
         idx = (int'(last_grant_r) + 1 + i) % num_req_p;
         if (!found && req_v_i[id_width_lp'(idx)]) begin
            found  = 1'b1;
            winner = id_width_lp'(idx);
         end
      end
   end

   always_comb begin
      state_n                = state_r;
      grant_n                = grant_r;
      last_grant_n           = last_grant_r;
      err_n                  = err_r;
      req_ready_o            = '0;
      complete_o             = '0;
      cache_req_v_o          = 1'b0;
      cache_req_metadata_v_o = 1'b0;
      cache_req_o            = req_arr[winner];
      cache_req_metadata_o   = meta_arr[grant_r];
      grant_id_o             = (state_r == e_idle) ? winner : grant_r;

      case (state_r)
         e_idle: begin
            cache_req_v_o = any_v;
            if (any_v)
               req_ready_o[winner] = cache_req_ready_i;
            if (any_v && cache_req_ready_i) begin
               grant_n = winner;
               state_n = e_meta;
            end
            if (cache_req_complete_i || (|meta_v_i))
               err_n = 1'b1;
         end
         e_meta: begin
            cache_req_metadata_v_o = meta_v_i[grant_r];
            if (meta_v_i[grant_r]) begin
               if (cache_req_complete_i) begin
                  complete_o[grant_r] = 1'b1;
                  last_grant_n        = grant_r;
                  state_n             = e_idle;
               end else begin
                  state_n = e_busy;
               end
            end else if (cache_req_complete_i) begin
               err_n = 1'b1;
            end
         end
         e_busy: begin
            if (cache_req_complete_i) begin
               complete_o[grant_r] = 1'b1;
               last_grant_n        = grant_r;
               state_n             = e_idle;
            end
         end
         default: state_n = e_idle;
      endcase

      // Handshake outputs are forced quiet for the whole reset cycle, not just after the edge.
      if (!reset_i) begin
         req_ready_o            = '0;
         complete_o             = '0;
         cache_req_v_o          = 1'b0;
         cache_req_metadata_v_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_r      <= e_idle;
         grant_r      <= '0;
         last_grant_r <= id_width_lp'(num_req_p - 1);
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_n;
         grant_r      <= grant_n;
         last_grant_r <= last_grant_n;
         err_r        <= err_n;
      end
   end

   assign err_o = err_r;

endmodule

// File: tb/tb_bp_be_cache_req_arb.sv
// Bench for bp_be_cache_req_arb: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model.
module tb_bp_be_cache_req_arb;
   localparam int N  = 2;
   localparam int RW = 64;
   localparam int MW = 8;

   logic            clk_sys = 1'b0;
   logic            reset_i;
   logic [N*RW-1:0] req_i;
   logic [N-1:0]    req_v_i;
   logic [N-1:0]    req_ready_o;
   logic [N*MW-1:0] meta_i;
   logic [N-1:0]    meta_v_i;
   logic [N-1:0]    complete_o;
   logic [RW-1:0]   cache_req_o;
   logic            cache_req_v_o;
   logic            cache_req_ready_i;
   logic [MW-1:0]   cache_req_metadata_o;
   logic            cache_req_metadata_v_o;
   logic            cache_req_complete_i;
   logic [0:0]      grant_id_o;
   logic            err_o;

   always #5 clk_sys = ~clk_sys;

   bp_be_cache_req_arb #(.num_req_p(N), .req_width_p(RW), .meta_width_p(MW)) dut (
      .clk_i(clk_sys), .reset_i(reset_i),
      .req_i(req_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
      .meta_i(meta_i), .meta_v_i(meta_v_i), .complete_o(complete_o),
      .cache_req_o(cache_req_o), .cache_req_v_o(cache_req_v_o),
      .cache_req_ready_i(cache_req_ready_i),
      .cache_req_metadata_o(cache_req_metadata_o),
      .cache_req_metadata_v_o(cache_req_metadata_v_o),
      .cache_req_complete_i(cache_req_complete_i),
      .grant_id_o(grant_id_o), .err_o(err_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: which phase of a transaction we are in, who holds it, who finished last.
   int m_phase = 0;   // 0 arbitrating, 1 awaiting metadata, 2 awaiting completion
   int m_grant = 0;
   int m_last  = N - 1;
   bit m_err   = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic cycle(input logic rst, input logic [N-1:0] rv, input logic rdy,
                        input logic [N-1:0] mv, input logic cmp);
      int       win;
      bit       any, found, fire, done;
      logic [N-1:0] e_ready, e_cmp;
      bit       e_v, e_mv;
      @(negedge clk_sys);
      reset_i = rst; req_v_i = rv; cache_req_ready_i = rdy;
      meta_v_i = mv; cache_req_complete_i = cmp;
      for (int n = 0; n < N; n++) begin
         req_i[n*RW +: RW]  = {$urandom, $urandom};
         meta_i[n*MW +: MW] = MW'($urandom);
      end
      #1;
      any = |rv; found = 0; win = 0;
      for (int k = 1; k <= N; k++)
         if (!found && rv[(m_last + k) % N]) begin found = 1; win = (m_last + k) % N; end
      e_ready = '0; e_cmp = '0; e_v = 0; e_mv = 0; fire = 0; done = 0;
      if (rst) begin
         if (m_phase == 0) begin
            e_v  = any;
            fire = any && rdy;
            if (fire) e_ready = N'(1 << win);
         end else if (m_phase == 1) begin
            e_mv = mv[m_grant];
            done = mv[m_grant] && cmp;
         end else begin
            done = cmp;
         end
         if (done) e_cmp = N'(1 << m_grant);
      end
      check("cache_req_v", 64'(cache_req_v_o), 64'(e_v));
      check("meta_v", 64'(cache_req_metadata_v_o), 64'(e_mv));
      check("complete", 64'(complete_o), 64'(e_cmp));
      check("err", 64'(err_o), 64'(m_err));
      if (!(rst && m_phase == 0 && !any)) check("req_ready", 64'(req_ready_o), 64'(e_ready));
      if (rst && m_phase == 0 && any) begin
         check("grant_id_idle", 64'(grant_id_o), 64'(win));
         check("cache_req", 64'(cache_req_o), 64'(req_i[win*RW +: RW]));
      end
      if (rst && m_phase != 0) check("grant_id_held", 64'(grant_id_o), 64'(m_grant));
      if (rst && m_phase == 1) check("metadata", 64'(cache_req_metadata_o), 64'(meta_i[m_grant*MW +: MW]));
      if (!rst) begin
         m_phase = 0; m_grant = 0; m_last = N - 1; m_err = 0;
      end else if (m_phase == 0) begin
         if (cmp || (|mv)) m_err = 1;
         if (fire) begin m_grant = win; m_phase = 1; end
      end else if (m_phase == 1) begin
         if (done) begin m_last = m_grant; m_phase = 0; end
         else if (mv[m_grant]) m_phase = 2;
         else if (cmp) m_err = 1;
      end else if (done) begin
         m_last = m_grant; m_phase = 0;
      end
   endtask

   initial begin
      logic [N-1:0] rv, mv;
      reset_i = 0; req_i = '0; req_v_i = '0; meta_i = '0; meta_v_i = '0;
      cache_req_ready_i = 0; cache_req_complete_i = 0;
      cycle(0, 2'b11, 1, 2'b11, 1);
      cycle(0, 2'b00, 0, 2'b00, 0);

      // single request on channel 0
      cycle(1, 2'b01, 1, 2'b00, 0);
      cycle(1, 2'b00, 1, 2'b01, 0);
      cycle(1, 2'b00, 1, 2'b00, 0);
      cycle(1, 2'b00, 1, 2'b00, 1);
      cycle(1, 2'b00, 1, 2'b00, 0);

      // round robin with both channels held, metadata and completion together
      cycle(0, 2'b00, 0, 2'b00, 0);
      for (int t = 0; t < 4; t++) begin
         cycle(1, 2'b11, 1, 2'b00, 0);
         check("rr_grant", 64'(grant_id_o), 64'(t % 2));
         cycle(1, 2'b11, 1, 2'b11, 1);
      end

      // backpressure on channel 1
      cycle(0, 2'b00, 0, 2'b00, 0);
      for (int t = 0; t < 5; t++) begin
         cycle(1, 2'b10, 0, 2'b00, 0);
         check("bp_hold_v", 64'(cache_req_v_o), 64'(1));
      end
      cycle(1, 2'b10, 1, 2'b00, 0);
      check("bp_fire_ready", 64'(req_ready_o), 64'(2'b10));

      // stray completion in idle sets sticky error
      cycle(0, 2'b00, 0, 2'b00, 0);
      cycle(1, 2'b00, 1, 2'b00, 1);
      for (int t = 0; t < 3; t++) cycle(1, 2'b00, 1, 2'b00, 0);
      check("err_sticky", 64'(err_o), 64'(1));
      cycle(0, 2'b00, 0, 2'b00, 0);

      // reset in the middle of a transaction on channel 1
      cycle(1, 2'b10, 1, 2'b00, 0);
      cycle(1, 2'b00, 1, 2'b10, 0);
      cycle(0, 2'b11, 1, 2'b11, 1);
      cycle(1, 2'b11, 1, 2'b00, 0);
      check("post_reset_grant", 64'(grant_id_o), 64'(0));

      for (int t = 0; t < 3000; t++) begin
         rv = N'($urandom);
         if (m_phase == 1 && $urandom_range(0, 1) == 1)
            mv = N'(1 << m_grant) | N'($urandom_range(0, 3) == 0 ? $urandom : 0);
         else
            mv = ($urandom_range(0, 24) == 0) ? N'($urandom) : '0;
         cycle($urandom_range(0, 199) != 0, rv, $urandom_range(0, 3) != 0, mv,
               $urandom_range(0, 2) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/bp_be_cache_req_arb.md
BP_BE_CACHE_REQ_ARB -- requirements
Module: bp_be_cache_req_arb

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of requester channels, legal range 1..8.
REQ-002 SHALL have parameter req_width_p, default 64: width of one cache request packet.
REQ-003 SHALL have parameter meta_width_p, default 8: width of one metadata packet.
REQ-004 SHALL define id_width_lp = max(1, clog2(num_req_p)).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_i, input, 1 bit: synchronous, active-low (0 = reset).
REQ-007 SHALL have port req_i, input, num_req_p*req_width_p: request packets; channel n occupies slice n.
REQ-008 SHALL have port req_v_i, input, num_req_p: per-channel request valid.
REQ-009 SHALL have port req_ready_o, output, num_req_p: per-channel request accept.
REQ-010 SHALL have port meta_i, input, num_req_p*meta_width_p: per-channel metadata packets.
REQ-011 SHALL have port meta_v_i, input, num_req_p: per-channel metadata valid.
REQ-012 SHALL have port complete_o, output, num_req_p: per-channel completion pulse.
REQ-013 SHALL have port cache_req_o, output, req_width_p: request to the LCE.
REQ-014 SHALL have port cache_req_v_o, output, 1 bit: request valid to the LCE.
REQ-015 SHALL have port cache_req_ready_i, input, 1 bit: LCE ready.
REQ-016 SHALL have port cache_req_metadata_o, output, meta_width_p: metadata to the LCE.
REQ-017 SHALL have port cache_req_metadata_v_o, output, 1 bit: metadata valid to the LCE.
REQ-018 SHALL have port cache_req_complete_i, input, 1 bit: LCE completion.
REQ-019 SHALL have port grant_id_o, output, id_width_lp: current or last granted channel.
REQ-020 SHALL have port err_o, output, 1 bit: sticky protocol-error flag.

Function
REQ-021 SHALL implement FSM states e_idle, e_meta and e_busy.
REQ-022 In e_idle, winner SHALL be the first asserted req_v_i bit searching round-robin from last_grant+1 (mod num_req_p).
REQ-023 In e_idle with any req_v_i set, cache_req_v_o=1 and cache_req_o=req_i[winner] SHALL be driven combinationally.
REQ-024 In e_idle, req_ready_o[winner]=cache_req_ready_i and all other req_ready_o bits SHALL be 0.
REQ-025 Fire (cache_req_v_o & cache_req_ready_i) in e_idle SHALL latch grant<=winner and transition to e_meta.
REQ-026 Outside e_idle, cache_req_v_o and all req_ready_o bits SHALL be 0.
REQ-027 In e_meta, cache_req_metadata_v_o=meta_v_i[grant] and cache_req_metadata_o=meta_i[grant] SHALL be driven combinationally; other channels' meta_v_i SHALL be ignored.
REQ-028 e_meta with meta_v_i[grant]=1 SHALL transition to e_busy, or directly to e_idle if cache_req_complete_i is also 1 that cycle.
REQ-029 e_busy with cache_req_complete_i=1 SHALL pulse complete_o[grant] the same cycle, set last_grant<=grant, and transition to e_idle.
REQ-030 complete_o SHALL be one-hot or zero and SHALL be 1 only in the completing cycle.
REQ-031 cache_req_complete_i in e_idle, or in e_meta without meta_v_i[grant], SHALL be ignored for state and SHALL set err_o.
REQ-032 meta_v_i[n] asserted in e_idle SHALL set err_o; err_o SHALL clear only on reset.
REQ-033 After completion, arbitration SHALL resume from e_idle the next cycle (one-cycle minimum gap between grants).
REQ-034 For num_req_p=1, the block SHALL degenerate to a pass-through sequencer with grant_id_o=0.
REQ-035 grant_id_o SHALL equal the grant register in e_meta and e_busy, and the winner in e_idle.
REQ-036 Request and metadata payloads SHALL NOT be registered (zero-latency combinational paths).

Reset
REQ-037 While reset_i=0 at a clock edge, the block SHALL set state=e_idle, last_grant=num_req_p-1 (channel 0 highest priority), grant=0 and err_o=0.
REQ-038 While reset_i=0, req_ready_o, complete_o, cache_req_v_o and cache_req_metadata_v_o SHALL be 0.
REQ-039 Reset asserted in e_meta or e_busy SHALL abandon the transaction without a complete_o pulse.

Verification
REQ-040 Single request: req_v_i=2'b01 with ready=1 SHALL fire in cycle 0, e_meta; meta_v_i[0] in cycle 1 SHALL give metadata_v_o=1; complete in cycle 3 SHALL give complete_o=2'b01 and e_idle in cycle 4.
REQ-041 Round-robin: req_v_i=2'b11 held SHALL produce grants 0,1,0,1 across four back-to-back transactions.
REQ-042 Backpressure: cache_req_ready_i=0 for 5 cycles with req_v_i[1]=1 SHALL hold cache_req_v_o=1, keep req_ready_o=0, and stay in e_idle; fire SHALL occur the cycle ready rises.
REQ-043 Same-cycle meta+complete: meta_v_i[grant] and cache_req_complete_i together in e_meta SHALL pulse complete_o and return to e_idle.
REQ-044 Error: cache_req_complete_i in e_idle SHALL leave the state unchanged and set err_o=1 until reset_i=0.
REQ-045 Mid-transaction reset: reset_i=0 in e_busy SHALL yield all outputs 0 and next grant to channel 0 when req_v_i=2'b11.
